// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - decode-stage hazard detection, forwarding select and stall/flush control
//
// Purpose: tracks the destination tags of instructions in flight after decode,
// selects forwarding sources for the two decode operands, detects load-use
// hazards, and produces stall/flush controls plus saturating event counters.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   id_valid                      decode holds a real instruction
//   id_rs1/id_rs2, id_rsN_used    source indices and their read flags
//   id_rd, id_regw, id_load       destination, writes-regfile flag, load flag
//   br_taken                      branch resolved taken this cycle
//   ext_stall                     memory busy, freezes the whole pipeline
//   stall, flush                  hold PC/decode + bubble; squash decode
//   fwd_sel1, fwd_sel2            0 = register file, k = forward from entry k
//   stall_cnt, flush_cnt          saturating event counters

module pipe_hazard_unit #(
    parameter int NREG  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 32,
    localparam int RW   = (NREG > 1) ? $clog2(NREG) : 1,
    localparam int FW   = (DEPTH > 1) ? $clog2(DEPTH + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RW-1:0]    id_rs1,
    input  logic [RW-1:0]    id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [RW-1:0]    id_rd,
    input  logic             id_regw,
    input  logic             id_load,
    input  logic             br_taken,
    input  logic             ext_stall,
    output logic             stall,
    output logic             flush,
    output logic [FW-1:0]    fwd_sel1,
    output logic [FW-1:0]    fwd_sel2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Tag pipe, entry 1 is the youngest instruction after decode.
    logic [DEPTH:1] v_q, v_d;
    logic [DEPTH:1] ld_q, ld_d;
    logic [RW-1:0]  rd_q [DEPTH:1];
    logic [RW-1:0]  rd_d [DEPTH:1];

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [FW-1:0] sel1, sel2;
    logic          load_use;
    logic          flush_int;
    logic          stall_int;

    // Forwarding select: scanning oldest to youngest leaves the youngest
    // (smallest k) match as the final value.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (id_rs1_used && (id_rs1 != '0) && v_q[k] && (rd_q[k] == id_rs1))
                sel1 = FW'(k);
            if (id_rs2_used && (id_rs2 != '0) && v_q[k] && (rd_q[k] == id_rs2))
                sel2 = FW'(k);
        end
    end

    // A load in entry 1 cannot supply data yet; with a single tracked stage
    // load data is assumed available, so load-use never fires.
    always_comb begin
        load_use = 1'b0;
        if (DEPTH > 1)
            load_use = id_valid && ld_q[1] &&
                       ((sel1 == FW'(1)) || (sel2 == FW'(1)));
        flush_int = br_taken && !ext_stall;
        stall_int = (load_use && !flush_int) || ext_stall;
    end

    always_comb begin
        v_d         = v_q;
        ld_d        = ld_q;
        rd_d        = rd_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (!ext_stall) begin
            for (int k = 2; k <= DEPTH; k++) begin
                v_d[k]  = v_q[k-1];
                ld_d[k] = ld_q[k-1];
                rd_d[k] = rd_q[k-1];
            end
            // x0 writers are never valid, so x0 never hazards.
            v_d[1]  = id_valid && id_regw && (id_rd != '0) && !flush_int && !load_use;
            ld_d[1] = id_load;
            rd_d[1] = id_rd;
        end

        if (stall_int && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_int && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q         <= '0;
            ld_q        <= '0;
            for (int k = 1; k <= DEPTH; k++)
                rd_q[k] <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            v_q         <= v_d;
            ld_q        <= ld_d;
            rd_q        <= rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Reset forces the control outputs low regardless of other inputs.
    assign stall     = stall_int && !rst;
    assign flush     = flush_int && !rst;
    assign fwd_sel1  = rst ? '0 : sel1;
    assign fwd_sel2  = rst ? '0 : sel2;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
